// File: rtl/subneg_bus_pkg.sv
// Shared types and constants for the SUBNEG external memory bus controller.
package subneg_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] BUS_DRIVE = 8'hFF;
    localparam logic [DATA_W-1:0] BUS_FLOAT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD,
        WD,
        WS,
        WH,
        RESP
    } state_e;

    // Down-counter load value for a phase lasting `cycles` cycles; 0 behaves as 1, clamp at 15.
    function automatic logic [3:0] wait_load(int unsigned cycles);
        if (cycles == 0) return 4'd0;
        if (cycles > 15) return 4'd14;
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/subneg_rr_arbiter.sv
// Two-way request arbiter: round-robin on ties, or fixed port-0 priority.
module subneg_rr_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_grant_q;

    // On a tie the port that did not win last time is favoured.
    always_comb begin
        grant_o = 2'b00;
        case (req_valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (FIXED_PRIO || last_grant_q) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept_i) begin
            last_grant_q <= grant_o[1];
        end
    end

endmodule

// File: rtl/subneg_mem_arbiter.sv
// Two-port owner of the multiplexed address/data memory bus: arbitrates,
// then sequences address latch, read or write strobes and a response pulse.
module subneg_mem_arbiter
    import subneg_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned OE_CYCLES    = 1,
    parameter int unsigned WE_CYCLES    = 1,
    parameter bit          FIXED_PRIO   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] bus_oe,
    input  logic [DATA_W-1:0] bus_in,
    output logic              le,
    output logic              moe,
    output logic              mwe,
    output logic              busy
);

    localparam logic [3:0] SETUP_LD = wait_load(SETUP_CYCLES);
    localparam logic [3:0] OE_LD    = wait_load(OE_CYCLES);
    localparam logic [3:0] WE_LD    = wait_load(WE_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              we_q;
    logic              id_q;
    logic [1:0]        grant;
    logic              accept;

    subneg_rr_arbiter #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_valid_i(req_valid),
        .accept_i   (accept),
        .grant_o    (grant)
    );

    assign req_ready = (state_q == IDLE) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ADDR;
                    cnt_d   = SETUP_LD;
                end
            end
            ADDR: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (we_q) begin
                    state_d = WD;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = RD;
                    cnt_d   = OE_LD;
                end
            end
            RD: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = RESP;
            end
            WD: begin
                state_d = WS;
                cnt_d   = WE_LD;
            end
            WS: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = WH;
            end
            WH:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= grant[1] ? req_addr1  : req_addr0;
                wdata_q <= grant[1] ? req_wdata1 : req_wdata0;
                we_q    <= grant[1] ? req_we[1]  : req_we[0];
                id_q    <= grant[1];
            end
            // Capture on the edge that closes the final output-enable cycle.
            if (state_q == RD && cnt_q == 4'd0) begin
                rdata_q <= bus_in;
            end
        end
    end

    // Pins decode only registered state, so request inputs never reach them.
    always_comb begin
        le        = (state_q == ADDR);
        moe       = (state_q == RD);
        mwe       = (state_q == WS);
        busy      = (state_q != IDLE);
        bus_oe    = BUS_FLOAT;
        bus_out   = '0;
        rsp_valid = 2'b00;
        case (state_q)
            ADDR: begin
                bus_oe  = BUS_DRIVE;
                bus_out = addr_q;
            end
            WD, WS, WH: begin
                bus_oe  = BUS_DRIVE;
                bus_out = wdata_q;
            end
            RESP:    rsp_valid = id_q ? 2'b10 : 2'b01;
            default: ;
        endcase
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_subneg_mem_arbiter.sv
// Bench for subneg_mem_arbiter: two configurations, each with a memory on the
// bus pins, a transaction-level reference model and directed plus random traffic.
`timescale 1ns/1ps
module tb_subneg_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(int i);
        return (i == 'h15) ? 8'hA5 : 8'(i * 37 + 11);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int S    = (g == 0) ? 1 : 2;
        localparam int O    = (g == 0) ? 1 : 3;
        localparam int W    = (g == 0) ? 1 : 2;
        localparam bit FP   = (g == 1);
        localparam int RLAT = S + O + 1;
        localparam int WLAT = S + W + 3;

        logic       rst;
        logic       v0, v1, we0, we1;
        logic [1:0] req_valid, req_ready, req_we, rsp_valid;
        logic [7:0] a0, a1, d0, d1, rsp_rdata, bus_out, bus_oe, bus_in;
        logic       le, moe, mwe, busy;
        logic [7:0] mem [256];
        logic [7:0] lat;
        bit         done = 1'b0;

        assign req_valid = {v1, v0};
        assign req_we    = {we1, we0};
        assign bus_in    = moe ? mem[lat] : 8'hEE;

        subneg_mem_arbiter #(
            .SETUP_CYCLES(S), .OE_CYCLES(O), .WE_CYCLES(W), .FIXED_PRIO(FP)
        ) dut (
            .clk(clk), .reset(rst),
            .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
            .req_addr0(a0), .req_addr1(a1), .req_wdata0(d0), .req_wdata1(d1),
            .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
            .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
            .le(le), .moe(moe), .mwe(mwe), .busy(busy)
        );

        // External latch + SRAM reacting only to the pins.
        initial begin : ext_mem
            lat = 8'h00;
            for (int i = 0; i < 256; i++) mem[i] = init_val(i);
            forever begin
                @(posedge clk);
                if (mwe) mem[lat] <= bus_out;
                if (le)  lat <= bus_out;
            end
        end

        // Reference: one transaction at a time, phase t counted from the accept edge.
        initial begin : model
            int         t, lastg, port, len;
            bit         we;
            logic [7:0] ad, wd, exp_rd;
            logic [1:0] win, e_ready, e_rv;
            logic [7:0] e_oe, e_out;
            logic       e_le, e_moe, e_mwe;
            logic [7:0] ref_mem [256];
            t = 0; lastg = 1; port = 0; we = 1'b0; ad = 0; wd = 0; exp_rd = 0;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            @(posedge clk);
            forever begin
                @(negedge clk);
                win = 2'b00;
                if (req_valid == 2'b01)      win = 2'b01;
                else if (req_valid == 2'b10) win = 2'b10;
                else if (req_valid == 2'b11) win = (FP || lastg == 1) ? 2'b01 : 2'b10;
                e_le = 0; e_moe = 0; e_mwe = 0; e_oe = 8'h00; e_out = 8'h00; e_rv = 2'b00;
                e_ready = (t == 0) ? win : 2'b00;
                if (t > 0) begin
                    if (t <= S) begin
                        e_le = 1; e_oe = 8'hFF; e_out = ad;
                    end else if (!we) begin
                        if (t <= S + O) e_moe = 1;
                        else e_rv = port ? 2'b10 : 2'b01;
                    end else if (t <= S + W + 2) begin
                        e_oe = 8'hFF; e_out = wd;
                        if (t >= S + 2 && t <= S + W + 1) e_mwe = 1;
                    end else begin
                        e_rv = port ? 2'b10 : 2'b01;
                    end
                end
                check("le", le, e_le);
                check("moe", moe, e_moe);
                check("mwe", mwe, e_mwe);
                check("bus_oe", bus_oe, e_oe);
                if (e_oe == 8'hFF) check("bus_out", bus_out, e_out);
                check("busy", busy, (t != 0));
                check("req_ready", req_ready, e_ready);
                check("rsp_valid", rsp_valid, e_rv);
                check("rsp_rdata", rsp_rdata, exp_rd);
                check("le_and_moe", le & moe, 0);
                check("moe_and_mwe", moe & mwe, 0);
                check("moe_and_drive", (moe && bus_oe == 8'hFF), 0);
                @(posedge clk);
                if (rst) begin
                    // A write cut off after its strobe has already hit memory.
                    if (t > 0 && we && t >= S + 2) ref_mem[ad] = wd;
                    t = 0; lastg = 1; exp_rd = 8'h00;
                end else if (t == 0) begin
                    if (win != 2'b00 && (req_valid & win) != 2'b00) begin
                        port  = (win == 2'b10) ? 1 : 0;
                        we    = req_we[port];
                        ad    = port ? a1 : a0;
                        wd    = port ? d1 : d0;
                        lastg = port;
                        t     = 1;
                    end
                end else begin
                    len = we ? WLAT : RLAT;
                    if (!we && t == S + O) exp_rd = ref_mem[ad];
                    if (we && t == WLAT) ref_mem[ad] = wd;
                    t = (t == len) ? 0 : t + 1;
                end
            end
        end

        task automatic cyc(input int n);
            repeat (n) @(posedge clk);
            #1;
        endtask

        // Returns in the first cycle after the accept edge.
        task automatic req(input int p, input bit w, input logic [7:0] a,
                           input logic [7:0] d, output bit ok);
            if (p == 0) begin we0 = w; a0 = a; d0 = d; v0 = 1'b1; end
            else        begin we1 = w; a1 = a; d1 = d; v1 = 1'b1; end
            ok = 1'b0;
            for (int k = 0; k < 1000 && !ok; k++) begin
                @(negedge clk);
                ok = req_ready[p];
                @(posedge clk);
                #1;
            end
            if (p == 0) v0 = 1'b0; else v1 = 1'b0;
        endtask

        initial begin : drv
            bit ok, ok1;
            int n;
            int seq [4];
            rst = 1'b1; v0 = 0; v1 = 0; we0 = 0; we1 = 0;
            a0 = 0; a1 = 0; d0 = 0; d1 = 0;
            cyc(2);
            rst = 1'b0;
            check("rst_bus_oe", bus_oe, 0);
            check("rst_rdata", rsp_rdata, 0);
            check("rst_busy", busy, 0);
            check("rst_rsp", rsp_valid, 0);

            // Port 0 read of 0x15 (memory holds A5).
            req(0, 1'b0, 8'h15, 8'h00, ok);
            check("rd_accept", ok, 1);
            check("rd_le", le, 1);
            check("rd_addr", bus_out, 8'h15);
            cyc(RLAT - 1);
            check("rd_rsp", rsp_valid, 2'b01);
            check("rd_data", rsp_rdata, 8'hA5);
            cyc(1);

            // Port 1 write 3C to 0x20, counting strobe width.
            req(1, 1'b1, 8'h20, 8'h3C, ok);
            check("wr_accept", ok, 1);
            check("wr_addr", bus_out, 8'h20);
            n = 0;
            for (int k = 1; k < WLAT; k++) begin
                if (mwe) n++;
                cyc(1);
            end
            check("wr_mwe_width", n, W);
            check("wr_rsp", rsp_valid, 2'b10);
            cyc(1);
            check("wr_mem", mem[8'h20], 8'h3C);

            // Reset while the write strobe is active.
            req(0, 1'b1, 8'h30, 8'h77, ok);
            n = 0;
            while (!mwe && n < 50) begin cyc(1); n++; end
            check("ws_reached", mwe, 1);
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
            check("rstws_mwe", mwe, 0);
            check("rstws_oe", bus_oe, 0);
            check("rstws_busy", busy, 0);
            check("rstws_rsp", rsp_valid, 0);
            req(0, 1'b0, 8'h01, 8'h00, ok);
            check("rd01_accept", ok, 1);
            cyc(RLAT - 1);
            check("rd01_rsp", rsp_valid, 2'b01);
            check("rd01_data", rsp_rdata, init_val(1));
            cyc(1);

            // Both ports held valid: record who is granted.
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
            we0 = 0; we1 = 0; a0 = 8'h05; a1 = 8'h06; v0 = 1; v1 = 1;
            n = 0;
            for (int k = 0; k < 200 && n < 4; k++) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin
                    seq[n] = req_ready[1];
                    n++;
                end
                @(posedge clk);
                #1;
            end
            v0 = 0; v1 = 0;
            check("grant_count", n, 4);
            for (int i = 0; i < 4; i++) check($sformatf("grant_%0d", i), seq[i], FP ? 0 : i % 2);
            cyc(RLAT + 2);

            // Random traffic on both ports over a small address window.
            fork
                begin
                    for (int k = 0; k < 30; k++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        req(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), ok);
                        check("rnd0_accept", ok, 1);
                    end
                end
                begin
                    for (int k = 0; k < 30; k++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        req(1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), ok1);
                        check("rnd1_accept", ok1, 1);
                    end
                end
            join
            cyc(RLAT + WLAT + 2);
            done = 1'b1;
        end
    end

    initial begin : top
        int k;
        k = 0;
        while (!(g_inst[0].done && g_inst[1].done) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        check("run_complete", (g_inst[0].done && g_inst[1].done), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/subneg_mem_arbiter.md
Name: subneg_mem_arbiter

Overview:
Two-port controller that owns the shared external memory bus of the SUBNEG core. The bus is a multiplexed 8-bit address/data bus with LE/MOE/MWE strobes. The controller accepts read/write requests from port 0 (CPU fetch/operand/result path) and port 1 (debug/loader). It arbitrates between them and runs the full address-latch / read / write strobe sequence. The top level connects its bus outputs to uio_out/uio_oe/uio_in and uo_out[2:0].

Parameters:
SETUP_CYCLES, 1, cycles LE is held high with the address driven (legal 1..15; 0 treated as 1)
OE_CYCLES, 1, cycles MOE is held high before read capture (1..15; 0 treated as 1)
WE_CYCLES, 1, MWE pulse width in cycles (1..15; 0 treated as 1)
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  2  per-port request valid; bit i = port i
req_ready  out  2  per-port accept; transfer when valid&ready at clk edge
req_we  in  2  per-port 1 = write, 0 = read
req_addr0, req_addr1  in  8  per-port address
req_wdata0, req_wdata1  in  8  per-port write data
rsp_valid  out  2  one-cycle completion pulse, bit = port id
rsp_rdata  out  8  read data; valid with rsp_valid
bus_out  out  8  to uio_out
bus_oe  out  8  to uio_oe (FF = drive, 00 = input)
bus_in  in  8  from uio_in
le, moe, mwe  out  1  external latch enable, memory output enable, memory write enable
busy  out  1  high in any state except IDLE

Behaviour:
- Clock is clk. Reset is named reset and is synchronous, active-high.
- Reset values: state=IDLE; le=moe=mwe=0; bus_oe=00; bus_out=00; rsp_valid=00; rsp_rdata=00; req_ready=00; last_grant=1, so port 0 wins the first tie.
- Reset mid-operation: on the next cycle all strobes are low and bus_oe=00. The in-flight transaction is dropped and no rsp_valid is issued.
- Bus outputs and rsp_* come from registered state only. There is no combinational path from request inputs to the pins.
- req_ready is combinational and is nonzero only in IDLE. At most one bit is set: the arbitration winner.
- Arbitration (IDLE only):
  - single valid: that port wins.
  - both valid, FIXED_PRIO=1: port 0 wins.
  - both valid, FIXED_PRIO=0: the port != last_grant wins.
  - last_grant updates on accept.
- On accept, the controller latches addr, we, wdata and id. Requesters must hold their inputs stable until accepted.
- States:
  - IDLE: strobes low, bus_oe=00. Accept -> ADDR.
  - ADDR: bus_out=addr, bus_oe=FF, le=1, for SETUP_CYCLES cycles. Then read -> RD, write -> WD.
  - RD: le=0, bus_oe=00, moe=1, for OE_CYCLES cycles. rsp_rdata <= bus_in on the clock edge that ends the last RD cycle. -> RESP.
  - WD: le=0, bus_out=wdata, bus_oe=FF, mwe=0, for 1 cycle (data setup). -> WS.
  - WS: as WD with mwe=1, for WE_CYCLES cycles. -> WH.
  - WH: mwe=0, data still driven, for 1 cycle (hold). -> RESP.
  - RESP: strobes low, bus_oe=00, rsp_valid[id]=1 for 1 cycle. Writes leave rsp_rdata unchanged. -> IDLE.
- Latency is counted from the accept edge to the cycle in which rsp_valid is high:
  - read = SETUP_CYCLES+OE_CYCLES+1 (defaults: 3)
  - write = SETUP_CYCLES+WE_CYCLES+3 (defaults: 5)
- Throughput: the IDLE cycle is mandatory between transactions, so the next accept is no earlier than the RESP cycle's following edge.
- Never: le and moe high together; moe and mwe high together; moe=1 with bus_oe=FF.
- Wait counter is 4 bits, loaded on state entry and counting down to 0.

Decomposition:
- Package subneg_bus_pkg:
  - ADDR_W=8, DATA_W=8
  - state enum (IDLE, ADDR, RD, WD, WS, WH, RESP)
  - BUS_DRIVE=8'hFF, BUS_FLOAT=8'h00
- Sub-module subneg_rr_arbiter: 2-way grant with last_grant register and FIXED_PRIO mode.

Test Plan:
- Port 0 read at 0x15, memory model returns 0xA5 while moe=1 -> le=1 one cycle with bus_out=15, oe=FF; then moe=1 one cycle with oe=00; rsp_valid=01 and rsp_rdata=A5 at cycle 3.
- Port 1 write 0x3C to 0x20 -> le with bus_out=20; mwe=1 exactly one cycle with bus_out=3C; data held one cycle after; rsp_valid=10 at cycle 5; model mem[20]=3C.
- Both ports valid continuously, FIXED_PRIO=0 -> grants 0,1,0,1. With FIXED_PRIO=1 -> port 0 starves port 1. req_ready=00 whenever busy=1.
- reset asserted during WS -> next cycle mwe=0, bus_oe=00, state IDLE, no rsp_valid. A following read to 0x01 completes normally.
- SETUP_CYCLES=2, OE_CYCLES=3, read -> le high 2 cycles, moe high 3 cycles, data captured at end of the third moe cycle, rsp at cycle 6.
- Strobe checker on every test -> le&moe, moe&mwe and moe&oe==FF never observed.
